// File: rtl/mem_bist_pkg.sv
// Shared types and LFSR helper for the mem_bist memory self-test initiator.
// The LFSR pattern is used only when MEM_BIST_LFSR_EN is defined.
package mem_bist_pkg;

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Right-shifting Galois LFSR step.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Test-pattern generator for mem_bist.
// MEM_BIST_LFSR_EN selects the LFSR sequence; otherwise the pattern is address XOR seed.
module mem_bist_pattern
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              load,
   input  logic              restart,
   input  logic              advance,
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] pattern
);

   logic [DATA_W-1:0] seed_q;

   always_ff @(posedge clk) begin
      if (load) seed_q <= seed;
   end

`ifdef MEM_BIST_LFSR_EN
   if (DATA_W != 8) begin : g_width_check
      $error("mem_bist_pattern: DATA_W must be 8 when MEM_BIST_LFSR_EN is defined");
   end

   logic [7:0] lfsr_q;
   logic [7:0] base;
   logic       unused_addr;

   // restart replays the sequence from the captured seed for the read-back phase
   assign base        = load ? seed[7:0] : seed_q[7:0];
   assign unused_addr = ^addr;

   always_ff @(posedge clk) begin
      if (load || restart)
         lfsr_q <= lfsr_next((base == 8'h00) ? 8'h01 : base);
      else if (advance)
         lfsr_q <= lfsr_next(lfsr_q);
   end

   assign pattern = DATA_W'(lfsr_q);
`else
   logic unused_ctl;

   assign unused_ctl = restart ^ advance;
   assign pattern    = DATA_W'(addr) ^ seed_q;
`endif

endmodule

// File: rtl/mem_bist.sv
// Memory BIST initiator: writes a pattern to every address, reads it back and compares.
// Optional MEM_BIST_LFSR_EN (in mem_bist_pattern) switches to an 8-bit LFSR pattern.
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   output logic              read,
   output logic              write
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              last_addr;
   logic              accept;
   logic [DATA_W-1:0] pattern;

   logic              vld_p0;
   logic [DATA_W-1:0] exp_p0;
   logic [ADDR_W-1:0] addr_p0;

   assign last_addr = &addr_q;
   assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = WRITE;
         WRITE:   if (last_addr) state_d = READ;
         READ:    if (last_addr) state_d = DRAIN;
         DRAIN:                  state_d = DONE;
         DONE:    if (accept)    state_d = WRITE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      read  = 1'b0;
      write = 1'b0;
      case (state_q)
         WRITE: begin busy = 1'b1; write = 1'b1; end
         READ:  begin busy = 1'b1; read  = 1'b1; end
         DRAIN: busy = 1'b1;
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Counter steps once per strobe and wraps to 0 after the last address of each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                addr_q <= '0;
      else if (write || read) addr_q <= addr_q + 1'b1;
   end

   mem_bist_pattern #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pattern (
      .clk     (clk),
      .load    (accept),
      .restart (write && last_addr),
      .advance (write || read),
      .seed    (seed),
      .addr    (addr_q),
      .pattern (pattern)
   );

   assign addr     = addr_q;
   assign data_out = write ? pattern : '0;
   assign pass     = done && (err_count == '0);

   // ---- stage p0: expected data travels one cycle behind the read strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= read;
   end

   always_ff @(posedge clk) begin
      exp_p0  <= pattern;
      addr_p0 <= addr_q;
   end

   // ---- compare: data_in is aligned with stage p0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (accept) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (vld_p0 && (data_in != exp_p0)) begin
         err_count <= err_count + 1'b1;
         if (err_count == '0) first_err_addr <= addr_p0;
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist with a behavioural memory responder and stuck-at fault injection.
module tb_mem_bist;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int LAT    = 2 * DEPTH + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [DATA_W-1:0] seed = '0;
   logic              busy, done, pass, read, write;
   logic [ADDR_W:0]   err_count;
   logic [ADDR_W-1:0] first_err_addr, addr;
   logic [DATA_W-1:0] data_out;
   logic [DATA_W-1:0] data_in = '0;

   logic [DATA_W-1:0] mem   [DEPTH];
   logic [DATA_W-1:0] stuck [DEPTH];

   typedef struct { int a; int d; } wr_t;
   typedef struct { int err; int first; int pass_e; } res_t;

   wr_t  wq[$];
   int   rq[$];
   res_t resq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   mem_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .seed           (seed),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .addr           (addr),
      .data_out       (data_out),
      .data_in        (data_in),
      .read           (read),
      .write          (write)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: read data appears one cycle after the strobe; stuck bits forced to 1.
   always @(posedge clk) begin
      if (write) mem[addr] <= data_out;
      if (read)  data_in   <= mem[addr] | stuck[addr];
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_pattern(input logic [7:0] sd, input int a);
`ifdef MEM_BIST_LFSR_EN
      logic [7:0] s;
      s = (sd == 8'h00) ? 8'h01 : sd;
      for (int i = 0; i <= a; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      return s;
`else
      return 8'(a) ^ sd;
`endif
   endfunction

   task automatic push_expect(input logic [7:0] sd);
      int errs;
      int first;
      logic [7:0] p;
      errs  = 0;
      first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         p = ref_pattern(sd, a);
         wq.push_back('{a, int'(p)});
         rq.push_back(a);
         if ((p | stuck[a]) != p) begin
            if (errs == 0) first = a;
            errs++;
         end
      end
      resq.push_back('{errs, first, (errs == 0) ? 1 : 0});
   endtask

   task automatic pulse_start(input logic [7:0] sd);
      logic was_done;
      @(negedge clk);
      was_done = done;
      start = 1'b1;
      seed  = sd;
      t0    = cyc;
      @(negedge clk);
      start = 1'b0;
      seed  = 8'($urandom);
      check("busy_after_start", int'(busy), 1);
      check("err_cleared", int'(err_count), 0);
      check("first_cleared", int'(first_err_addr), 0);
      if (was_done) check("done_cleared", int'(done), 0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 4 * DEPTH + 20) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", int'(done), 1);
      @(negedge clk);
   endtask

   task automatic run(input logic [7:0] sd, input int glitch_addr);
      int n;
      push_expect(sd);
      pulse_start(sd);
      if (glitch_addr >= 0) begin
         n = 0;
         while (!(write && int'(addr) == glitch_addr) && n < 4 * DEPTH) begin
            @(negedge clk);
            n++;
         end
         check("glitch_reached", int'(write && int'(addr) == glitch_addr), 1);
         start = 1'b1;
         seed  = 8'($urandom);
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe or finishes a run.
   initial begin
      logic done_prev;
      wr_t  w;
      int   ra;
      res_t r;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_prev = 1'b0;
            continue;
         end
         if (read && write) check("strobe_exclusive", 1, 0);
         if (read || write) check("busy_in_phase", int'(busy), 1);
         if (write) begin
            if (wq.size() == 0) check("unexpected_write", 1, 0);
            else begin
               w = wq.pop_front();
               check("wr_addr", int'(addr), w.a);
               check("wr_data", int'(data_out), w.d);
            end
         end
         if (read) begin
            if (rq.size() == 0) check("unexpected_read", 1, 0);
            else begin
               ra = rq.pop_front();
               check("rd_addr", int'(addr), ra);
            end
         end
         if (done && !done_prev) begin
            if (resq.size() == 0) check("unexpected_done", 1, 0);
            else begin
               r = resq.pop_front();
               check("err_count", int'(err_count), r.err);
               check("first_err_addr", int'(first_err_addr), r.first);
               check("pass", int'(pass), r.pass_e);
               check("latency", cyc - t0, LAT);
               check("busy_in_done", int'(busy), 0);
            end
         end
         done_prev = done;
      end
   end

   initial begin
      int n;
      for (int a = 0; a < DEPTH; a++) stuck[a] = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_read", int'(read), 0);
      check("rst_write", int'(write), 0);
      check("rst_err_count", int'(err_count), 0);
      check("rst_first_err", int'(first_err_addr), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_data_out", int'(data_out), 0);
      rst = 1'b0;
      @(negedge clk);

      run(8'h00, -1);

      stuck[5] = 8'h02;
      run(8'h00, -1);
      stuck[5] = 8'h00;

      // back-to-back from DONE with a nonzero error count still showing
      run(8'hFF, -1);

      run(8'($urandom), 10);

      for (int k = 0; k < 4; k++) begin
         for (int a = 0; a < DEPTH; a++) stuck[a] = '0;
         for (int f = 0; f < k; f++) stuck[$urandom_range(0, DEPTH - 1)] = 8'(1 << $urandom_range(0, 7));
         run(8'($urandom), -1);
      end
      for (int a = 0; a < DEPTH; a++) stuck[a] = '0;

      // abort by reset during the read phase
      push_expect(8'h3C);
      pulse_start(8'h3C);
      n = 0;
      while (!(read && addr == 5'd7) && n < 4 * DEPTH) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached", int'(read && addr == 5'd7), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_read", int'(read), 0);
      check("abort_write", int'(write), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_err_count", int'(err_count), 0);
      wq.delete();
      rq.delete();
      resq.delete();
      @(negedge clk);
      rst = 1'b0;

      run(8'($urandom), -1);

      check("wq_drained", wq.size(), 0);
      check("rq_drained", rq.size(), 0);
      check("resq_drained", resq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
